// File: rtl/multicycle_control.sv
// ----------------------------------------------------------------------------
// multicycle_control
//   Multi-cycle instruction sequencer. It steps each instruction through
//   FETCH / DECODE / EXECUTE / MEMORY / WRITEBACK, stalls on the memory-ready
//   handshake, traps bus timeouts into a sticky ERROR state, stops in a
//   sticky HALT state and counts retired instructions (saturating).
//
// Ports
//   clk_i, rst_i       clock, synchronous active-high reset
//   opCode_i           IR opcode, sampled in DECODE only
//   zero_i             ALU zero flag, sampled in BRANCH
//   memReady_i         memory completes the current read/write this cycle
//   pcWrite_o .. pcSource_o   datapath mux selects and write strobes,
//                      decoded from the current state
//   halted_o           sticky, HALT executed
//   busError_o         sticky, memory timeout
//   instrCount_o       retired-instruction count, saturating
//   state_o            current state code (debug)
// ----------------------------------------------------------------------------
module multicycle_control #(
    parameter int unsigned OPCODE_W    = 4,
    parameter int unsigned ALUOP_W     = 4,
    parameter int unsigned MEM_TIMEOUT = 16,
    parameter int unsigned CNT_W       = 16
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic [OPCODE_W-1:0] opCode_i,
    input  logic                zero_i,
    input  logic                memReady_i,
    output logic                pcWrite_o,
    output logic                irWrite_o,
    output logic                iorD_o,
    output logic                memRead_o,
    output logic                memWrite_o,
    output logic                regDst_o,
    output logic                memToReg_o,
    output logic                regWrite_o,
    output logic                aluSrcA_o,
    output logic [1:0]          aluSrcB_o,
    output logic [ALUOP_W-1:0]  aluOp_o,
    output logic [1:0]          pcSource_o,
    output logic                halted_o,
    output logic                busError_o,
    output logic [CNT_W-1:0]    instrCount_o,
    output logic [3:0]          state_o
);

    localparam int unsigned WAIT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT + 1) : 1;

    typedef enum logic [3:0] {
        S_IDLE     = 4'd0,
        S_FETCH    = 4'd1,
        S_DECODE   = 4'd2,
        S_MEM_ADDR = 4'd3,
        S_MEM_RD   = 4'd4,
        S_MEM_WR   = 4'd5,
        S_WB_MEM   = 4'd6,
        S_EXEC_R   = 4'd7,
        S_WB_R     = 4'd8,
        S_EXEC_I   = 4'd9,
        S_WB_I     = 4'd10,
        S_BRANCH   = 4'd11,
        S_JUMP     = 4'd12,
        S_HALT     = 4'd13,
        S_ERROR    = 4'd14
    } state_e;

    localparam logic [3:0] OP_R    = 4'h0;
    localparam logic [3:0] OP_LW   = 4'h1;
    localparam logic [3:0] OP_BEQ  = 4'h2;
    localparam logic [3:0] OP_ORI  = 4'h3;
    localparam logic [3:0] OP_SW   = 4'h4;
    localparam logic [3:0] OP_ANDI = 4'h5;
    localparam logic [3:0] OP_ADDI = 4'h6;
    localparam logic [3:0] OP_SLTI = 4'h7;
    localparam logic [3:0] OP_J    = 4'h8;
    localparam logic [3:0] OP_HALT = 4'hF;

    state_e              state_q, state_d;
    logic [3:0]          op_q, op_d;
    logic [WAIT_W-1:0]   wait_q, wait_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                halted_q, halted_d;
    logic                busError_q, busError_d;

    logic [3:0]          op_lo;
    logic                op_wide;
    logic                timeout_hit;
    logic                retire;
    logic [ALUOP_W-1:0]  alu_imm;

    // Opcodes with any bit set above the 4-bit map decode as NOP.
    assign op_lo = opCode_i[3:0];
    generate
        if (OPCODE_W > 4) begin : g_wide
            assign op_wide = |opCode_i[OPCODE_W-1:4];
        end else begin : g_narrow
            assign op_wide = 1'b0;
        end
    endgenerate

    // The current wait cycle is the last one allowed before the trap.
    assign timeout_hit = (MEM_TIMEOUT != 0) && (wait_q == WAIT_W'(MEM_TIMEOUT - 1));

    // Immediate ALU function from the opcode latched in DECODE.
    always_comb begin
        alu_imm = ALUOP_W'(4'b1000);
        case (op_q)
            OP_ORI:  alu_imm = ALUOP_W'(4'b1011);
            OP_ANDI: alu_imm = ALUOP_W'(4'b1010);
            OP_SLTI: alu_imm = ALUOP_W'(4'b1111);
            default: alu_imm = ALUOP_W'(4'b1000);
        endcase
    end

    // Next-state, wait counter and opcode capture.
    always_comb begin
        state_d = state_q;
        wait_d  = '0;
        op_d    = op_q;
        case (state_q)
            S_IDLE:     state_d = S_FETCH;
            S_FETCH, S_MEM_RD, S_MEM_WR: begin
                if (memReady_i) begin
                    if (state_q == S_FETCH)      state_d = S_DECODE;
                    else if (state_q == S_MEM_RD) state_d = S_WB_MEM;
                    else                          state_d = S_FETCH;
                end else if (timeout_hit) begin
                    state_d = S_ERROR;
                end else if (MEM_TIMEOUT != 0) begin
                    wait_d = wait_q + WAIT_W'(1);
                end
            end
            S_DECODE: begin
                op_d    = op_lo;
                state_d = S_FETCH;
                if (!op_wide) begin
                    case (op_lo)
                        OP_R:                             state_d = S_EXEC_R;
                        OP_LW, OP_SW:                     state_d = S_MEM_ADDR;
                        OP_BEQ:                           state_d = S_BRANCH;
                        OP_ORI, OP_ANDI, OP_ADDI, OP_SLTI: state_d = S_EXEC_I;
                        OP_J:                             state_d = S_JUMP;
                        OP_HALT:                          state_d = S_HALT;
                        default:                          state_d = S_FETCH;
                    endcase
                end
            end
            S_MEM_ADDR: state_d = (op_q == OP_SW) ? S_MEM_WR : S_MEM_RD;
            S_WB_MEM:   state_d = S_FETCH;
            S_EXEC_R:   state_d = S_WB_R;
            S_WB_R:     state_d = S_FETCH;
            S_EXEC_I:   state_d = S_WB_I;
            S_WB_I:     state_d = S_FETCH;
            S_BRANCH:   state_d = S_FETCH;
            S_JUMP:     state_d = S_FETCH;
            S_HALT:     state_d = S_HALT;
            S_ERROR:    state_d = S_ERROR;
            default:    state_d = S_IDLE;
        endcase

        retire     = (state_d == S_FETCH) && (state_q != S_FETCH) && (state_q != S_IDLE);
        cnt_d      = (retire && (cnt_q != '1)) ? cnt_q + CNT_W'(1) : cnt_q;
        halted_d   = halted_q | (state_d == S_HALT);
        busError_d = busError_q | (state_d == S_ERROR);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= S_IDLE;
            op_q       <= '0;
            wait_q     <= '0;
            cnt_q      <= '0;
            halted_q   <= 1'b0;
            busError_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            wait_q     <= wait_d;
            cnt_q      <= cnt_d;
            halted_q   <= halted_d;
            busError_q <= busError_d;
        end
    end

    // Datapath controls decoded from state; only memory completion uses memReady.
    always_comb begin
        pcWrite_o  = 1'b0;
        irWrite_o  = 1'b0;
        iorD_o     = 1'b0;
        memRead_o  = 1'b0;
        memWrite_o = 1'b0;
        regDst_o   = 1'b0;
        memToReg_o = 1'b0;
        regWrite_o = 1'b0;
        aluSrcA_o  = 1'b0;
        aluSrcB_o  = 2'b00;
        aluOp_o    = '0;
        pcSource_o = 2'b00;
        case (state_q)
            S_FETCH: begin
                memRead_o = 1'b1;
                aluSrcB_o = 2'b01;
                aluOp_o   = ALUOP_W'(4'b1000);
                irWrite_o = memReady_i;
                pcWrite_o = memReady_i;
            end
            S_DECODE: begin
                aluSrcB_o = 2'b11;
                aluOp_o   = ALUOP_W'(4'b1000);
            end
            S_MEM_ADDR: begin
                aluSrcA_o = 1'b1;
                aluSrcB_o = 2'b10;
                aluOp_o   = ALUOP_W'(4'b1000);
            end
            S_MEM_RD: begin
                memRead_o = 1'b1;
                iorD_o    = 1'b1;
            end
            S_MEM_WR: begin
                memWrite_o = 1'b1;
                iorD_o     = 1'b1;
            end
            S_WB_MEM: begin
                regWrite_o = 1'b1;
                memToReg_o = 1'b1;
            end
            S_EXEC_R:   aluSrcA_o = 1'b1;
            S_WB_R: begin
                regWrite_o = 1'b1;
                regDst_o   = 1'b1;
            end
            S_EXEC_I: begin
                aluSrcA_o = 1'b1;
                aluSrcB_o = 2'b10;
                aluOp_o   = alu_imm;
            end
            S_WB_I: begin
                regWrite_o = 1'b1;
                aluOp_o    = alu_imm;
            end
            S_BRANCH: begin
                aluSrcA_o  = 1'b1;
                aluOp_o    = ALUOP_W'(4'b1001);
                pcSource_o = 2'b01;
                pcWrite_o  = zero_i;
            end
            S_JUMP: begin
                pcSource_o = 2'b10;
                pcWrite_o  = 1'b1;
            end
            default: ;
        endcase
    end

    assign halted_o     = halted_q;
    assign busError_o   = busError_q;
    assign instrCount_o = cnt_q;
    assign state_o      = 4'(state_q);

endmodule

// File: tb/tb_multicycle_control.sv
// ----------------------------------------------------------------------------
// tb_multicycle_control
//   Scoreboard bench. The driver walks each instruction through the phases
//   its opcode class implies, pushing the expected per-cycle control word;
//   an independent monitor pops and compares on the falling edge.
// ----------------------------------------------------------------------------
module tb_multicycle_control;

    localparam int OPW = 5;
    localparam int AW  = 4;
    localparam int TMO = 4;
    localparam int CW  = 4;
    localparam int CNT_MAX = (1 << CW) - 1;

    logic           clk = 1'b0;
    logic           rst;
    logic [OPW-1:0] opCode;
    logic           zero;
    logic           memReady;
    logic           pcWrite, irWrite, iorD, memRead, memWrite;
    logic           regDst, memToReg, regWrite, aluSrcA;
    logic [1:0]     aluSrcB;
    logic [AW-1:0]  aluOp;
    logic [1:0]     pcSource;
    logic           halted, busError;
    logic [CW-1:0]  instrCount;
    logic [3:0]     state;

    always #5 clk = ~clk;

    multicycle_control #(
        .OPCODE_W(OPW), .ALUOP_W(AW), .MEM_TIMEOUT(TMO), .CNT_W(CW)
    ) dut (
        .clk_i(clk), .rst_i(rst), .opCode_i(opCode), .zero_i(zero),
        .memReady_i(memReady),
        .pcWrite_o(pcWrite), .irWrite_o(irWrite), .iorD_o(iorD),
        .memRead_o(memRead), .memWrite_o(memWrite), .regDst_o(regDst),
        .memToReg_o(memToReg), .regWrite_o(regWrite), .aluSrcA_o(aluSrcA),
        .aluSrcB_o(aluSrcB), .aluOp_o(aluOp), .pcSource_o(pcSource),
        .halted_o(halted), .busError_o(busError), .instrCount_o(instrCount),
        .state_o(state)
    );

    typedef struct packed {
        logic [3:0]    st;
        logic          pcWrite, irWrite, iorD, memRead, memWrite;
        logic          regDst, memToReg, regWrite, aluSrcA;
        logic [1:0]    aluSrcB;
        logic [AW-1:0] aluOp;
        logic [1:0]    pcSource;
        logic          halted, busError;
        logic [CW-1:0] cnt;
    } rec_t;

    rec_t q[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model state
    logic halted_m = 1'b0;
    logic err_m    = 1'b0;
    int   cnt_m    = 0;

    function automatic rec_t base(input logic [3:0] st);
        rec_t r;
        r          = '0;
        r.st       = st;
        r.halted   = halted_m;
        r.busError = err_m;
        r.cnt      = CW'(cnt_m);
        return r;
    endfunction

    // Monitor: one comparison per cycle that has an expectation queued.
    always @(negedge clk) begin
        rec_t a, e;
        if (q.size() != 0) begin
            e = q.pop_front();
            a.st = state;       a.pcWrite = pcWrite;   a.irWrite = irWrite;
            a.iorD = iorD;      a.memRead = memRead;   a.memWrite = memWrite;
            a.regDst = regDst;  a.memToReg = memToReg; a.regWrite = regWrite;
            a.aluSrcA = aluSrcA; a.aluSrcB = aluSrcB;  a.aluOp = aluOp;
            a.pcSource = pcSource; a.halted = halted;  a.busError = busError;
            a.cnt = instrCount;
            checks++;
            if (a !== e) begin
                errors++;
                $display("FAIL ctrl_word t=%0t: got st=%0d word=%h, expected st=%0d word=%h",
                         $time, a.st, a, e.st, e);
            end
        end
    end

    task automatic step(input rec_t e, input logic mr);
        memReady = mr;
        q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    function automatic logic rbit();
        return 1'($urandom_range(0, 1));
    endfunction

    task automatic retire();
        if (cnt_m < CNT_MAX) cnt_m++;
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1;
        memReady = rbit();
        repeat (n) @(posedge clk);
        #1;
        rst = 1'b0;
        halted_m = 1'b0;
        err_m    = 1'b0;
        cnt_m    = 0;
        step(base(4'd0), rbit());
    endtask

    task automatic error_tail(input int n);
        err_m = 1'b1;
        for (int i = 0; i < n; i++) begin
            opCode = OPW'($urandom);
            step(base(4'd14), rbit());
        end
    endtask

    task automatic fetch(input int fw, output bit to);
        rec_t w, d;
        w = base(4'd1);
        w.memRead = 1'b1; w.aluSrcB = 2'b01; w.aluOp = 4'b1000;
        d = w;
        d.irWrite = 1'b1; d.pcWrite = 1'b1;
        to = 1'b0;
        for (int i = 0; i < fw && i < TMO; i++) begin
            opCode = OPW'($urandom);
            step(w, 1'b0);
        end
        if (fw >= TMO) to = 1'b1;
        else begin
            opCode = OPW'($urandom);
            step(d, 1'b1);
        end
    endtask

    task automatic mem_phase(input logic [3:0] st, input bit wr, input int mw, output bit to);
        rec_t w;
        w = base(st);
        w.iorD = 1'b1;
        if (wr) w.memWrite = 1'b1;
        else    w.memRead  = 1'b1;
        to = 1'b0;
        for (int i = 0; i < mw && i < TMO; i++) step(w, 1'b0);
        if (mw >= TMO) to = 1'b1;
        else step(w, 1'b1);
    endtask

    // One instruction: phases chosen from the opcode class.
    task automatic run_instr(input logic [OPW-1:0] op, input logic z, input int fw, input int mw);
        bit         to;
        rec_t       e;
        logic [3:0] lo;
        logic [3:0] ia;
        fetch(fw, to);
        if (to) begin error_tail(20); return; end
        opCode = op;
        e = base(4'd2); e.aluSrcB = 2'b11; e.aluOp = 4'b1000;
        step(e, rbit());
        opCode = OPW'($urandom);
        zero   = rbit();
        if (op > OPW'(15)) begin retire(); return; end
        lo = op[3:0];
        case (lo)
            4'h0: begin
                e = base(4'd7); e.aluSrcA = 1'b1; step(e, rbit());
                e = base(4'd8); e.regWrite = 1'b1; e.regDst = 1'b1; step(e, rbit());
            end
            4'h1, 4'h4: begin
                e = base(4'd3); e.aluSrcA = 1'b1; e.aluSrcB = 2'b10; e.aluOp = 4'b1000;
                step(e, rbit());
                mem_phase((lo == 4'h1) ? 4'd4 : 4'd5, lo == 4'h4, mw, to);
                if (to) begin error_tail(20); return; end
                if (lo == 4'h1) begin
                    e = base(4'd6); e.regWrite = 1'b1; e.memToReg = 1'b1; step(e, rbit());
                end
            end
            4'h2: begin
                zero = z;
                e = base(4'd11); e.aluSrcA = 1'b1; e.aluOp = 4'b1001;
                e.pcSource = 2'b01; e.pcWrite = z;
                step(e, rbit());
            end
            4'h3, 4'h5, 4'h6, 4'h7: begin
                ia = (lo == 4'h3) ? 4'b1011 : (lo == 4'h5) ? 4'b1010 :
                     (lo == 4'h6) ? 4'b1000 : 4'b1111;
                e = base(4'd9); e.aluSrcA = 1'b1; e.aluSrcB = 2'b10; e.aluOp = ia;
                step(e, rbit());
                e = base(4'd10); e.regWrite = 1'b1; e.aluOp = ia; step(e, rbit());
            end
            4'h8: begin
                e = base(4'd12); e.pcSource = 2'b10; e.pcWrite = 1'b1; step(e, rbit());
            end
            4'hF: begin
                halted_m = 1'b1;
                for (int i = 0; i < 6; i++) begin
                    opCode = OPW'($urandom);
                    step(base(4'd13), rbit());
                end
                return;
            end
            default: ;
        endcase
        retire();
    endtask

    // Store that is interrupted by reset while waiting on memory.
    task automatic sw_abort();
        bit   to;
        rec_t e;
        fetch(0, to);
        opCode = OPW'(4);
        e = base(4'd2); e.aluSrcB = 2'b11; e.aluOp = 4'b1000; step(e, 1'b0);
        e = base(4'd3); e.aluSrcA = 1'b1; e.aluSrcB = 2'b10; e.aluOp = 4'b1000; step(e, 1'b0);
        e = base(4'd5); e.memWrite = 1'b1; e.iorD = 1'b1;
        step(e, 1'b0);
        step(e, 1'b0);
        do_reset(1);
    endtask

    initial begin
        logic [OPW-1:0] op;
        int             r, fw, mw;
        rst = 1'b1; opCode = '0; zero = 1'b0; memReady = 1'b0;
        do_reset(2);

        // Directed cases
        run_instr(OPW'(0), 1'b0, 0, 0);
        run_instr(OPW'(1), 1'b0, 0, 3);
        run_instr(OPW'(2), 1'b1, 0, 0);
        run_instr(OPW'(2), 1'b0, 1, 0);
        run_instr(OPW'(10), 1'b0, 0, 0);
        run_instr(OPW'(16), 1'b0, 0, 0);
        run_instr(OPW'(4), 1'b0, 2, 1);
        run_instr(OPW'(8), 1'b0, 0, 0);

        // Random instruction stream (drives the counter into saturation)
        for (int n = 0; n < 150; n++) begin
            r = $urandom_range(0, 19);
            if (r < 16) op = (r == 15) ? OPW'(10) : OPW'(r);
            else        op = OPW'(16 + $urandom_range(0, 15));
            fw = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 3) : 0;
            mw = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 3) : 0;
            run_instr(op, rbit(), fw, mw);
        end

        // HALT is terminal until reset
        do_reset(2);
        run_instr(OPW'(6), 1'b0, 0, 0);
        run_instr(OPW'(15), 1'b0, 0, 0);

        // Fetch timeout, then reset recovery
        do_reset(2);
        run_instr(OPW'(0), 1'b0, TMO, 0);

        // Load and store timeouts
        do_reset(2);
        run_instr(OPW'(1), 1'b0, 1, TMO);
        do_reset(2);
        run_instr(OPW'(3), 1'b0, 0, 0);
        run_instr(OPW'(4), 1'b0, 0, TMO);

        // Reset in the middle of a store wait
        do_reset(2);
        run_instr(OPW'(5), 1'b0, 0, 0);
        run_instr(OPW'(7), 1'b0, 1, 0);
        sw_abort();
        run_instr(OPW'(0), 1'b0, 0, 0);
        run_instr(OPW'(1), 1'b0, 0, 0);

        @(negedge clk);
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
